// File: rtl/credit_based_buffer.sv
`default_nettype none
// ============================================================================
// Module   : credit_based_buffer
// Purpose  : Synchronous FIFO with credit-based flow control on both links.
//            Write side issues credits: DEPTH credits after reset, then one
//            credit per drained entry. Read side consumes credits from a
//            pool of READ_CREDITS, replenished by read_credit pulses.
// Ports    : clock, resetn (async, active-low)
//            write_data/write_valid in, write_credit out (registered)
//            read_data/read_valid out (FWFT, read_valid is the pop), read_credit in
//            level/empty/full status, overflow/credit_overflow error pulses
// Options  : CREDIT_BASED_BUFFER_CHECKS_EN - drives the error pulses and adds
//            simulation-only assertions; otherwise the error ports are tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module credit_based_buffer #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int READ_CREDITS = 4
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [WIDTH-1:0]             write_data,
    input  logic                         write_valid,
    output logic                         write_credit,
    output logic [WIDTH-1:0]             read_data,
    output logic                         read_valid,
    input  logic                         read_credit,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         credit_overflow
);

    localparam int LEVEL_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int RC_W    = $clog2(READ_CREDITS + 1);

    localparam logic [LEVEL_W-1:0] C_DEPTH    = LEVEL_W'(DEPTH);
    localparam logic [PTR_W-1:0]   C_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [RC_W-1:0]    C_RC_MAX   = RC_W'(READ_CREDITS);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] r_pending;
    logic [RC_W-1:0]    r_rd_credits;
    logic               r_write_credit;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [LEVEL_W-1:0] w_pending_next;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == C_DEPTH);
    assign w_pop   = ~w_empty & (r_rd_credits != '0);
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign w_push  = write_valid & (~w_full | w_pop);
    // Freed slots awaiting a grant; never exceeds DEPTH so no extra bit needed.
    assign w_pending_next = r_pending + LEVEL_W'(w_pop);

    assign read_valid   = w_pop;
    assign read_data    = r_mem[r_rd_ptr];
    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign write_credit = r_write_credit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_pending      <= C_DEPTH;
            r_rd_credits   <= C_RC_MAX;
            r_write_credit <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_level <= r_level + LEVEL_W'(w_push) - LEVEL_W'(w_pop);

            // Returns at a full pool saturate rather than wrap.
            if (read_credit && !w_pop) begin
                if (r_rd_credits != C_RC_MAX) begin
                    r_rd_credits <= r_rd_credits + RC_W'(1);
                end
            end else if (!read_credit && w_pop) begin
                r_rd_credits <= r_rd_credits - RC_W'(1);
            end

            // Release at most one credit per cycle, oldest backlog first.
            if (w_pending_next != '0) begin
                r_write_credit <= 1'b1;
                r_pending      <= w_pending_next - LEVEL_W'(1);
            end else begin
                r_write_credit <= 1'b0;
                r_pending      <= w_pending_next;
            end
        end
    end

    // Storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

`ifdef CREDIT_BASED_BUFFER_CHECKS_EN
    logic r_overflow;
    logic r_credit_overflow;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow        <= 1'b0;
            r_credit_overflow <= 1'b0;
        end else begin
            r_overflow        <= write_valid & w_full & ~w_pop;
            r_credit_overflow <= read_credit & ~w_pop & (r_rd_credits == C_RC_MAX);
        end
    end

    assign overflow        = r_overflow;
    assign credit_overflow = r_credit_overflow;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (resetn) begin
            assert (r_pending <= C_DEPTH);
            assert (r_level <= C_DEPTH);
        end
    end
`endif
`else
    assign overflow        = 1'b0;
    assign credit_overflow = 1'b0;
`endif

endmodule
`default_nettype wire
